// File: rtl/bus_arb4.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb4
// Brief    : Round-robin arbiter/sequencer sharing one 32-bit channel among
//            four requesters. Optional per-grant beat cap: BUS_ARB_BEATCAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arb4 #(
    parameter int MAX_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] din0,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic [31:0] din3,
    input  logic        out_ready,
    output logic [3:0]  gnt,
    output logic [1:0]  sel,
    output logic [3:0]  rdy,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    localparam logic [7:0] c_last_beat = 8'(MAX_BEATS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [7:0] r_beat_cnt;
    logic [7:0] w_beat_cnt_nxt;

    logic       w_xfer;
    logic       w_cap_hit;
    logic       w_found;
    logic [1:0] w_pick;

    assign busy      = (r_state == S_OWN);
    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign rdy       = r_gnt & {4{out_ready}};
    assign out_valid = busy & req[r_sel];
    assign w_xfer    = out_valid & out_ready;

    always_comb begin
        out_data = 32'h0;
        if (out_valid) begin
            case (r_sel)
                2'd0:    out_data = din0;
                2'd1:    out_data = din1;
                2'd2:    out_data = din2;
                default: out_data = din3;
            endcase
        end
    end

    // First requester at or after the round-robin pointer, wrapping mod 4.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && req[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_ptr + 2'(k);
            end
        end
    end

`ifdef BUS_ARB_BEATCAP_EN
    assign w_cap_hit = w_xfer && (r_beat_cnt == c_last_beat);
`else
    // The beat counter still runs but never forces release in this build.
    logic w_unused_ok;
    assign w_cap_hit   = 1'b0;
    assign w_unused_ok = &{1'b0, r_beat_cnt, c_last_beat};
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_sel_nxt      = r_sel;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_OWN;
                    w_gnt_nxt      = 4'b0001 << w_pick;
                    w_sel_nxt      = w_pick;
                    w_beat_cnt_nxt = 8'd0;
                end
            end
            S_OWN: begin
                if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                end
                // sel is kept on release; only the pointer moves past the owner.
                if (!req[r_sel] || w_cap_hit) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_ptr_nxt   = r_sel + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'd0;
            r_ptr      <= 2'd0;
            r_beat_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arb4.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arb4
// Brief    : Self-checking bench for bus_arb4 with a beat scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arb4;

    localparam int MAX_BEATS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din0, din1, din2, din3;
    logic        out_ready;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [3:0]  rdy;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    bus_arb4 #(.MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .rdy       (rdy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [1:0] i, input logic [31:0] d);
        beat_t b;
        b.idx  = i;
        b.data = d;
        exp_q.push_back(b);
    endtask

    // Every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: sel=%0d data=%h, required no beat", sel, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (sel !== mon_e.idx || out_data !== mon_e.data || rdy !== (4'b0001 << mon_e.idx)) begin
                    n_fail++;
                    $display("FAIL beat_data: sel=%0d data=%h rdy=%b, required sel=%0d data=%h rdy=%b",
                             sel, out_data, rdy, mon_e.idx, mon_e.data, 4'b0001 << mon_e.idx);
                end
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
        din0 = 32'h1000_0000; din1 = 32'h1000_0001; din2 = 32'h1000_0002; din3 = 32'h1000_0003;
        for (int c = 0; c < 2; c++) begin
            tick; #2;
            n_checks++;
            if (gnt !== 4'b0 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 ||
                out_data !== 32'h0 || rdy !== 4'b0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: gnt=%b sel=%0d busy=%b vld=%b data=%h rdy=%b, required all zero",
                         c, gnt, sel, busy, out_valid, out_data, rdy);
            end
        end
        rst_n = 1'b1; req = 4'b0000;
    endtask

    task automatic test_single_grant;
        tick;
        req = 4'b0100; din2 = 32'hDEADBEEF; out_ready = 1'b1;
        push_beat(2'd2, 32'hDEADBEEF);
        #2;
        n_checks++;
        if (busy !== 1'b0 || gnt !== 4'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_latency: busy=%b gnt=%b vld=%b, required 0 0000 0", busy, gnt, out_valid);
        end
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b1 ||
            out_data !== 32'hDEADBEEF || rdy !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b sel=%0d busy=%b vld=%b data=%h rdy=%b, required 0100 2 1 1 deadbeef 0100",
                     gnt, sel, busy, out_valid, out_data, rdy);
        end
        tick; req = 4'b0000; #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL owner_drop: vld=%b data=%h gnt=%b, required 0 0 0100", out_valid, out_data, gnt);
        end
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL release: gnt=%b busy=%b sel=%0d, required 0000 0 2", gnt, busy, sel);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_beats: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin_wrap;
        din0 = 32'hA0A0_0000; din3 = 32'hD3D3_0003;
        tick; req = 4'b1001; push_beat(2'd3, din3);
        tick; #2;
        n_checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            n_fail++;
            $display("FAIL rr_after_2: gnt=%b sel=%0d, required 1000 3", gnt, sel);
        end
        tick; req = 4'b0000;
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_release: gnt=%b busy=%b, required 0000 0", gnt, busy);
        end
        req = 4'b1001; push_beat(2'd0, din0);
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL rr_wrap: gnt=%b sel=%0d, required 0001 0", gnt, sel);
        end
        tick; req = 4'b0000;
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_end: gnt=%b busy=%b pending=%0d, required 0000 0 0", gnt, busy, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        din1 = 32'hCAFE_0001;
        tick; req = 4'b0010; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick; #2;
            n_checks++;
            if (out_valid !== 1'b1 || rdy !== 4'b0 || gnt !== 4'b0010) begin
                n_fail++;
                $display("FAIL bp_stall cyc%0d: vld=%b rdy=%b gnt=%b, required 1 0000 0010", c, out_valid, rdy, gnt);
            end
        end
        for (int c = 0; c < 3; c++) push_beat(2'd1, din1);
        for (int c = 0; c < 3; c++) begin
            tick; out_ready = 1'b1; #2;
            n_checks++;
            if (out_valid !== 1'b1 || rdy !== 4'b0010 || gnt !== 4'b0010) begin
                n_fail++;
                $display("FAIL bp_flow cyc%0d: vld=%b rdy=%b gnt=%b, required 1 0010 0010", c, out_valid, rdy, gnt);
            end
        end
        tick; req = 4'b0000;
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_end: gnt=%b pending=%0d, required 0000 0", gnt, exp_q.size());
        end
    endtask

    task automatic test_beat_cap;
        logic [3:0] exp_gnt[$];
        din0 = 32'hB0B0_0000; din1 = 32'hB1B1_0001;
`ifdef BUS_ARB_BEATCAP_EN
        for (int b = 0; b < MAX_BEATS; b++) begin exp_gnt.push_back(4'b0001); push_beat(2'd0, din0); end
        exp_gnt.push_back(4'b0000);
        for (int b = 0; b < MAX_BEATS; b++) begin exp_gnt.push_back(4'b0010); push_beat(2'd1, din1); end
        exp_gnt.push_back(4'b0000);
        exp_gnt.push_back(4'b0001); push_beat(2'd0, din0);
`else
        for (int b = 0; b < 10; b++) begin exp_gnt.push_back(4'b0001); push_beat(2'd0, din0); end
`endif
        tick; req = 4'b0011; out_ready = 1'b1; #2;
        n_checks++;
        if (gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL cap_start: gnt=%b, required 0000", gnt);
        end
        foreach (exp_gnt[c]) begin
            tick; #2;
            n_checks++;
            if (gnt !== exp_gnt[c] || out_valid !== (exp_gnt[c] != 4'b0)) begin
                n_fail++;
                $display("FAIL cap_seq cyc%0d: gnt=%b vld=%b, required gnt=%b", c, gnt, out_valid, exp_gnt[c]);
            end
        end
        tick; req = 4'b0000;
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL cap_end: gnt=%b busy=%b pending=%0d, required 0000 0 0", gnt, busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        din1 = 32'hC1C1_0001; din2 = 32'hC2C2_0002;
        tick; req = 4'b0010; out_ready = 1'b1;
        push_beat(2'd1, din1); push_beat(2'd1, din1);
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL rmid_grant: gnt=%b, required 0010", gnt);
        end
        tick;
        tick; rst_n = 1'b0; out_ready = 1'b0;
        tick; rst_n = 1'b1; #2;
        n_checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || out_valid !== 1'b0 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_reset: gnt=%b busy=%b vld=%b sel=%0d, required 0000 0 0 0", gnt, busy, out_valid, sel);
        end
        tick; out_ready = 1'b1; push_beat(2'd1, din1); #2;
        n_checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            n_fail++;
            $display("FAIL rmid_regrant: gnt=%b sel=%0d, required 0010 1", gnt, sel);
        end
        tick; req = 4'b0000;
        // Grant requester 2, reset mid-grant, then all request: pointer must be back at 0.
        tick; req = 4'b0100; out_ready = 1'b0;
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL rptr_grant: gnt=%b, required 0100", gnt);
        end
        rst_n = 1'b0;
        tick; rst_n = 1'b1; req = 4'b1111; #2;
        n_checks++;
        if (gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL rptr_reset: gnt=%b, required 0000", gnt);
        end
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL rptr_regrant: gnt=%b sel=%0d, required 0001 0", gnt, sel);
        end
        req = 4'b0000;
        tick;
        tick; #2;
        n_checks++;
        if (gnt !== 4'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rmid_end: gnt=%b pending=%0d, required 0000 0", gnt, exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
        din0 = 32'h0; din1 = 32'h0; din2 = 32'h0; din3 = 32'h0;
        test_reset;
        test_single_grant;
        test_round_robin_wrap;
        test_backpressure;
        test_beat_cap;
        test_reset_mid;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arb4.md
# bus_arb4

Round-robin arbiter and sequencer that shares one 32-bit downstream channel among four requesters. It owns the select of the channel's 32-bit 4:1 data multiplexer, locks a grant to one requester for a multi-beat transfer, and forwards a valid/ready handshake between the granted requester and the sink. It sits between the four producer ports (e.g. pipeline stages or DMA-style sources) and the single consumer port of the shared bus.

## Interface
- MAX_BEATS, 4: beat cap per grant, used only when BUS_ARB_BEATCAP_EN is defined; legal range 1..255.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- req  in  4  per-requester request/valid; bit i = requester i has a beat ready
- din0, din1, din2, din3  in  32 each  requester data
- out_ready  in  1  sink accepts the current beat
- gnt  out  4  one-hot registered grant, 0 when idle
- sel  out  2  registered mux select = index of owner
- rdy  out  4  per-requester beat accepted, = gnt & {4{out_ready}}
- out_valid  out  1  = busy & req[sel]
- out_data  out  32  din[sel] when out_valid, else 32'h0
- busy  out  1  registered, 1 in state OWN

## Operation
- States: IDLE, OWN. Registers: state, gnt, sel, ptr[1:0] (round-robin start), beat_cnt[7:0].
- IDLE: if req != 0, pick first i with req[i]=1 scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); next cycle state=OWN, gnt=1<<i, sel=i, beat_cnt=0. If req == 0, stay IDLE, registers hold.
- OWN: a beat transfers in any cycle with out_valid & out_ready; beat_cnt increments (mod 256) on each transfer.
- OWN release: when req[sel]=0 -> next cycle IDLE, gnt=0, ptr=sel+1 (mod 4, wraps 3->0); sel holds its value.
- Owner dropping req mid-transfer is legal; no beat is counted in that cycle.
- Non-owner req changes in OWN are ignored. No preemption.
- Data path is purely combinational from sel; no data is registered in this block.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE, gnt=0, sel=0, ptr=0, beat_cnt=0, busy=0; hence rdy=0, out_valid=0, out_data=0. Applies from any state, mid-transfer included; an in-flight beat is dropped.
- Grant latency: req seen in IDLE at edge N -> gnt/busy/sel valid after edge N, first beat possible in cycle N+1.
- Every ownership change passes through at least one IDLE cycle (one-cycle arbitration bubble).
- Handshake: transfer occurs exactly in cycles where out_valid=1 and out_ready=1; out_ready may be held low indefinitely; requester must keep din stable while req=1 and rdy=0.
- out_valid, out_data, rdy respond combinationally to req, din, out_ready in the same cycle.

## Configuration
- BUS_ARB_BEATCAP_EN defined: in OWN, a transfer with beat_cnt = MAX_BEATS-1 forces release -> next cycle IDLE, gnt=0, ptr=sel+1, regardless of req[sel]. Release on req[sel]=0 still applies. Guarantees each requester waits at most 3*(MAX_BEATS+1) cycles under continuous ready.
- Not defined: owner holds grant until its req drops; beat_cnt still counts but never forces release; MAX_BEATS unused.

## Test plan
- Reset: drive req=4'b1111, out_ready=1, rst_n=0 for 2 cycles -> gnt=0, sel=0, busy=0, out_valid=0, out_data=0 throughout.
- Single grant: after reset, req=4'b0100, din2=32'hDEADBEEF, out_ready=1 -> one cycle later gnt=4'b0100, sel=2, out_data=32'hDEADBEEF, rdy=4'b0100; drop req -> next cycle IDLE, ptr=3.
- Round-robin wrap: ptr=3 (after serving requester 2), req=4'b1001 -> requester 3 granted; after release, req=4'b1001 -> requester 0 granted (ptr wrapped to 0).
- Backpressure: owner 1 holding req, out_ready=0 for 5 cycles -> out_valid=1, rdy=0, beat_cnt unchanged; out_ready=1 -> one beat counted per cycle.
- Beat cap (macro on, MAX_BEATS=4): req=4'b0011 held, out_ready=1 -> requester 0 gets 4 beats, 1 IDLE cycle, requester 1 gets 4 beats, IDLE, requester 0 again; macro off -> requester 0 keeps grant indefinitely.
- Reset mid-transfer: owner 1 after 2 beats, rst_n=0 one cycle -> IDLE, ptr=0, gnt=0; with req=4'b0010 held, requester 1 regranted one cycle after rst_n returns high.
